// File: rtl/button_digit_entry_pkg.sv
// Shared glyph constants (led[0:7] = a..g, dp) and debouncer state encoding.
// Used by the button entry block and the seven-segment display path.
package button_digit_entry_pkg;

   typedef logic [0:7] seg_t;

   localparam seg_t SEG_0 = 8'b1111_1100;
   localparam seg_t SEG_1 = 8'b0110_0000;
   localparam seg_t SEG_2 = 8'b1101_1010;
   localparam seg_t SEG_3 = 8'b1111_0010;
   localparam seg_t SEG_4 = 8'b0110_0110;
   localparam seg_t SEG_5 = 8'b1011_0110;
   localparam seg_t SEG_6 = 8'b1011_1110;
   localparam seg_t SEG_7 = 8'b1110_0000;
   localparam seg_t SEG_8 = 8'b1111_1110;
   localparam seg_t SEG_9 = 8'b1111_0110;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_e;

   function automatic seg_t seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = SEG_0;
         4'd1:    seg_of = SEG_1;
         4'd2:    seg_of = SEG_2;
         4'd3:    seg_of = SEG_3;
         4'd4:    seg_of = SEG_4;
         4'd5:    seg_of = SEG_5;
         4'd6:    seg_of = SEG_6;
         4'd7:    seg_of = SEG_7;
         4'd8:    seg_of = SEG_8;
         4'd9:    seg_of = SEG_9;
         default: seg_of = 8'b0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus tick-driven debounce FSM for one raw button.
// BUTTON_DIGIT_AUTOREPEAT_EN adds a repeat counter while the button is held.
module button_debouncer
   import button_digit_entry_pkg::*;
#(
   parameter int DEBOUNCE_MS = 10,
   parameter int REPEAT_MS   = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_MS + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

   if (DEBOUNCE_MS < 1 || REPEAT_MS < 1) begin : g_bad_param
      $error("button_debouncer: DEBOUNCE_MS and REPEAT_MS must be >= 1");
   end

   logic            sync1_q, sync2_q;
   db_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_MS + 1);
   localparam logic [RW-1:0] RLAST = RW'(REPEAT_MS - 1);
   logic [RW-1:0]   rpt_q, rpt_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= DB_IDLE;
         cnt_q   <= '0;
`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   // A one-tick debounce window skips the wait states entirely.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
      rpt_d   = rpt_q;
`endif
      if (tick) begin
         case (state_q)
            DB_IDLE: begin
               if (sync2_q) begin
                  if (LAST == '0) begin
                     state_d = DB_PRESSED;
                     press   = 1'b1;
                  end else begin
                     state_d = DB_PRESS_WAIT;
                     cnt_d   = CW'(1);
                  end
               end
            end
            DB_PRESS_WAIT: begin
               if (!sync2_q) begin
                  state_d = DB_IDLE;
               end else if (cnt_q >= LAST) begin
                  state_d = DB_PRESSED;
                  press   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DB_PRESSED: begin
               if (!sync2_q) begin
                  state_d = (LAST == '0) ? DB_IDLE : DB_RELEASE_WAIT;
                  cnt_d   = CW'(1);
`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
                  rpt_d   = '0;
               end else if (rpt_q >= RLAST) begin
                  press = 1'b1;
                  rpt_d = '0;
               end else begin
                  rpt_d = rpt_q + 1'b1;
`endif
               end
            end
            DB_RELEASE_WAIT: begin
               if (sync2_q) begin
                  state_d = DB_PRESSED;
               end else if (cnt_q >= LAST) begin
                  state_d = DB_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = DB_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/button_digit_entry.sv
// Up/down push-button digit entry: ms tick, two debouncers, BCD + segment output.
// Optional auto-repeat while held: define BUTTON_DIGIT_AUTOREPEAT_EN.
module button_digit_entry
   import button_digit_entry_pkg::*;
#(
   parameter int ms_limit    = 100000,
   parameter int DEBOUNCE_MS = 10,
   parameter int REPEAT_MS   = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up_raw,
   input  logic       btn_dn_raw,
   output logic [3:0] digit,
   output logic [0:7] led,
   output logic       changed
);

   localparam int MW = $clog2(ms_limit);

   if (ms_limit < 2) begin : g_bad_param
      $error("button_digit_entry: ms_limit must be >= 2");
   end

   logic [MW-1:0] ms_cnt_q, ms_cnt_d;
   logic          tick;
   logic          up_ev, dn_ev;
   logic [3:0]    digit_q, digit_d;
   seg_t          led_q, led_d;
   logic          changed_q, changed_d;

   assign tick     = (ms_cnt_q == MW'(ms_limit - 1));
   assign ms_cnt_d = tick ? '0 : ms_cnt_q + 1'b1;

   button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS), .REPEAT_MS(REPEAT_MS)) u_up (
      .clk(clk), .rst(rst), .tick(tick), .raw(btn_up_raw), .press(up_ev)
   );

   button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS), .REPEAT_MS(REPEAT_MS)) u_dn (
      .clk(clk), .rst(rst), .tick(tick), .raw(btn_dn_raw), .press(dn_ev)
   );

   // Coincident up and down events cancel each other.
   always_comb begin
      digit_d   = digit_q;
      changed_d = 1'b0;
      if (up_ev && !dn_ev) begin
         digit_d   = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
         changed_d = 1'b1;
      end else if (dn_ev && !up_ev) begin
         digit_d   = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
         changed_d = 1'b1;
      end
      led_d = seg_of(digit_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ms_cnt_q  <= '0;
         digit_q   <= 4'd0;
         led_q     <= SEG_0;
         changed_q <= 1'b0;
      end else begin
         ms_cnt_q  <= ms_cnt_d;
         digit_q   <= digit_d;
         led_q     <= led_d;
         changed_q <= changed_d;
      end
   end

   assign digit   = digit_q;
   assign led     = led_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_button_digit_entry.sv
// Directed bench for button_digit_entry with ms_limit=4, DEBOUNCE_MS=3, REPEAT_MS=5.
module tb_button_digit_entry;

`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
   localparam int HOLD = 20;
`else
   localparam int HOLD = 40;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up_raw;
   logic       btn_dn_raw;
   logic [3:0] digit;
   logic [0:7] led;
   logic       changed;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int p0;

   logic [0:7] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   always #5 clk = ~clk;

   button_digit_entry #(.ms_limit(4), .DEBOUNCE_MS(3), .REPEAT_MS(5)) dut (
      .clk(clk), .rst(rst), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
      .digit(digit), .led(led), .changed(changed)
   );

   always @(negedge clk) if (changed === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic press(input logic up, input logic dn, input int hold);
      btn_up_raw = up;
      btn_dn_raw = dn;
      step(hold);
      btn_up_raw = 1'b0;
      btn_dn_raw = 1'b0;
      step(30);
   endtask

   initial begin
      // reset with the up button already held
      rst = 1'b1; btn_up_raw = 1'b1; btn_dn_raw = 1'b0;
      step(3);
      chk("rst_digit", digit, 0);
      chk("rst_led", led, 8'b1111_1100);
      chk("rst_pulses", pulses, 0);
      rst = 1'b0;
      step(8);
      chk("requal_early_digit", digit, 0);
      step(HOLD - 8);
      btn_up_raw = 1'b0;
      step(30);
      chk("p1_pulses", pulses, 1);
      chk("p1_digit", digit, 1);
      chk("p1_led", led, 8'b0110_0000);

      p0 = pulses;
      press(1'b1, 1'b0, HOLD);
      chk("p2_pulses", pulses - p0, 1);
      chk("p2_digit", digit, 2);
      chk("p2_led", led, 8'b1101_1010);

      // bounce: never stable for three consecutive ticks
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         btn_up_raw = (i % 2 == 0);
         step(3);
      end
      btn_up_raw = 1'b0;
      step(30);
      chk("bounce_pulses", pulses - p0, 0);
      chk("bounce_digit", digit, 2);

      for (int i = 0; i < 7; i++) press(1'b1, 1'b0, HOLD);
      chk("up_to9_digit", digit, 9);
      chk("up_to9_led", led, 8'b1111_0110);
      press(1'b1, 1'b0, HOLD);
      chk("wrap_up_digit", digit, 0);
      chk("wrap_up_led", led, 8'b1111_1100);
      press(1'b0, 1'b1, HOLD);
      chk("wrap_dn_digit", digit, 9);
      chk("wrap_dn_led", led, 8'b1111_0110);

      p0 = pulses;
      press(1'b1, 1'b1, HOLD);
      chk("both_pulses", pulses - p0, 0);
      chk("both_digit", digit, 9);

      // walk down through every glyph
      p0 = pulses;
      for (int d = 8; d >= 0; d--) begin
         press(1'b0, 1'b1, HOLD);
         chk("sweep_digit", digit, d);
         chk("sweep_led", led, seg_tab[d]);
      end
      chk("sweep_pulses", pulses - p0, 9);

`ifdef BUTTON_DIGIT_AUTOREPEAT_EN
      p0 = pulses;
      btn_up_raw = 1'b1;
      step(100);
      chk("rpt_digit_range", (digit >= 4 && digit <= 6), 1);
      chk("rpt_pulses", pulses - p0, digit);
      chk("rpt_led", led, seg_tab[digit]);
      btn_up_raw = 1'b0;
      step(30);
      chk("rpt_after_release", pulses - p0, digit);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_digit_entry.md
Name: button_digit_entry

Overview:
- Input-side counterpart to the fake seven-segment LED display.
- Takes two raw push-buttons (up/down), synchronizes and debounces them on a millisecond tick, and edits one decimal digit.
- Emits the digit in BCD and as an 8-bit segment pattern in the same LED ordering the display path drives, so board LEDs can echo user entry.

Parameters:
- ms_limit, 100000: clk cycles per 1 ms tick at 100 MHz; must be >= 2.
- DEBOUNCE_MS, 10: consecutive ms ticks a button level must hold before it is accepted; must be >= 1.
- REPEAT_MS, 250: auto-repeat period in ms. Only used when AUTOREPEAT_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_up_raw  in  1  asynchronous raw button, active-high.
- btn_dn_raw  in  1  asynchronous raw button, active-high.
- digit  out  4  current BCD digit, 0..9.
- led  out  [0:7]  segment pattern: led[0..6]=a..g, led[7]=dp, active-high.
- changed  out  1  one-cycle pulse in the cycle digit/led take a new value.

Behaviour:
- Reset, synchronous: one clk edge with rst=1 clears all state.
  - Outputs: digit=0, led=8'b1111_1100 (glyph "0"), changed=0.
  - Internal: ms counter=0, debouncers in IDLE, synchronizers=0.
  - Reset asserted mid-debounce or mid-press discards the pending event. A button still held after reset must re-qualify through IDLE.
- Tick generator:
  - ms_cnt counts 0..ms_limit-1 and wraps.
  - tick=1 for one cycle when ms_cnt==ms_limit-1.
- Synchronizer: two flops per button. Edges arrive at the debouncer 2 cycles late.
- Debouncer FSM, one per button; all transitions evaluated only on tick cycles:
  - IDLE: sync=1 -> PRESS_WAIT, stable counter=1.
  - PRESS_WAIT: sync=0 -> IDLE. Else counter++. When counter reaches DEBOUNCE_MS -> PRESSED and assert press event for that one cycle.
  - PRESSED: sync=0 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: sync=1 -> PRESSED with no new event. Else counter++. When counter reaches DEBOUNCE_MS -> IDLE.
  - Stable counter width is clog2(DEBOUNCE_MS+1).
- Digit update, registered; takes effect the cycle after the press event:
  - up only: 9 -> 0, else +1.
  - down only: 0 -> 9, else -1.
  - Both in the same cycle: no change, changed stays 0.
  - On any change, changed=1 for exactly one cycle.
- Segment encoding: registered together with digit, so led always matches digit.
  - Glyphs 0..9 (abcdefg): 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - dp=0 always.
- Latency, raw press held stable to changed pulse: 2 sync cycles + up to ms_limit cycles to the first tick + (DEBOUNCE_MS-1)·ms_limit + 1 cycle.
- A single held press produces exactly one event.

Optional Feature:
- Macro: BUTTON_DIGIT_AUTOREPEAT_EN.
- Defined:
  - While a debouncer stays in PRESSED, a repeat counter advances on each tick.
  - Every REPEAT_MS ticks after entry to PRESSED it generates another press event; the counter restarts on each event.
  - Leaving PRESSED clears the counter.
  - Repeat events follow the same simultaneous-event rule.
- Undefined: no repeat logic is synthesized; one event per press.

Decomposition:
- Shared package / header:
  - 8-bit segment glyph constants SEG_0..SEG_9 in [0:7] led order, also used by the display path.
  - Debouncer state encoding localparams (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
- Sub-module button_debouncer:
  - Contents: synchronizer + FSM + optional repeat.
  - Ports: clk, rst, tick, raw, press.
  - Instantiated twice. The tick generator and digit/segment registers stay in the top of this block.

Test Plan (ms_limit=4, DEBOUNCE_MS=3, REPEAT_MS=5):
1. Reset -> digit=0, led=11111100, changed=0. Hold rst 3 cycles while btn_up_raw=1 -> still 0 and no pulse; after release of rst, one event arrives only after full requalification.
2. btn_up_raw held 40 cycles -> exactly one changed pulse, digit=1, led=01100000. A second press -> digit=2, led=11011010.
3. Bounce: btn_up_raw toggles every 3 cycles for 30 cycles, then stays 0 -> no changed pulse, digit unchanged.
4. Wrap: from 9, press up -> digit=0, led=11111100. From 0, press down -> digit=9, led=11110110.
5. Simultaneous: both buttons pressed on the same cycle and held 40 cycles -> both events coincide, no change, changed stays 0.
6. With BUTTON_DIGIT_AUTOREPEAT_EN: hold up for 100 cycles from digit=0 -> first event, then one event every 20 cycles; digit=5 at 100 cycles (±1 by tick phase), each step accompanied by a single changed pulse.
